// File: rtl/dag_unit.sv
// Data address generator: I/M register file, combinational address formation and post-modify update.
// Define CIRC_BUF_EN to add L/B registers and circular-buffer wrapping of post-modify updates.
module dag_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps_dg_en,
  input  logic        ps_dg_dgsclt,
  input  logic        ps_dg_mdfy,
  input  logic [2:0]  ps_dg_iadd,
  input  logic [2:0]  ps_dg_madd,
  input  logic [4:0]  ps_dg_rd_add,
  input  logic [4:0]  ps_dg_wrt_add,
  input  logic        ps_dg_wrt_en,
  input  logic [15:0] bc_dt,
  output logic [15:0] dg_dm_add,
  output logic [15:0] dg_ps_add,
  output logic [15:0] dg_bc_dt
);

  logic [15:0] i_reg [8];
  logic [15:0] m_reg [8];
`ifdef CIRC_BUF_EN
  logic [15:0] l_reg [8];
  logic [15:0] b_reg [8];
`endif

  logic [15:0] i_cur;
  logic [15:0] sum;
  logic [15:0] addr;
  logic [15:0] post_val;
  logic [15:0] rd_val;
  logic [2:0]  wr_idx;
  logic [2:0]  rd_idx;

  assign i_cur  = i_reg[ps_dg_iadd];
  assign sum    = i_cur + m_reg[ps_dg_madd];
  // Pre-modify addresses are never wrapped, even with circular buffering compiled in.
  assign addr   = ps_dg_mdfy ? sum : i_cur;
  assign wr_idx = ps_dg_wrt_add[2:0];
  assign rd_idx = ps_dg_rd_add[2:0];

`ifdef CIRC_BUF_EN
  logic [15:0] l_cur;
  logic [15:0] b_cur;
  logic [16:0] buf_end;

  assign l_cur   = l_reg[ps_dg_iadd];
  assign b_cur   = b_reg[ps_dg_iadd];
  assign buf_end = {1'b0, b_cur} + {1'b0, l_cur};

  // The stepped pointer is taken mod 2^16 first, then compared against a 17-bit buffer end.
  always_comb begin
    post_val = sum;
    if (l_cur != 16'h0000) begin
      if ({1'b0, sum} >= buf_end) post_val = sum - l_cur;
      else if (sum < b_cur)       post_val = sum + l_cur;
    end
  end
`else
  assign post_val = sum;
`endif

  // NOTE: the register file is built from flops, so it can and must be cleared by reset;
  // a RAM macro would not allow this loop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 8; k++) begin
        i_reg[k] <= '0;
        m_reg[k] <= '0;
`ifdef CIRC_BUF_EN
        l_reg[k] <= '0;
        b_reg[k] <= '0;
`endif
      end
    end else begin
      if (ps_dg_en && !ps_dg_mdfy) i_reg[ps_dg_iadd] <= post_val;
      // NOTE: a later non-blocking write to the same element overrides an earlier one,
      // which gives ureg writes priority over the post-modify update.
      if (ps_dg_wrt_en) begin
        case (ps_dg_wrt_add[4:3])
          2'b00: i_reg[wr_idx] <= bc_dt;
          2'b01: m_reg[wr_idx] <= bc_dt;
`ifdef CIRC_BUF_EN
          2'b10: l_reg[wr_idx] <= bc_dt;
          2'b11: begin
            b_reg[wr_idx] <= bc_dt;
            i_reg[wr_idx] <= bc_dt;
          end
`else
          2'b10, 2'b11: ;
`endif
          default: ;
        endcase
      end
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    rd_val = '0;
    case (ps_dg_rd_add[4:3])
      2'b00: rd_val = i_reg[rd_idx];
      2'b01: rd_val = m_reg[rd_idx];
`ifdef CIRC_BUF_EN
      2'b10: rd_val = l_reg[rd_idx];
      2'b11: rd_val = b_reg[rd_idx];
`endif
      default: rd_val = '0;
    endcase
    if (ps_dg_wrt_en && (ps_dg_wrt_add == ps_dg_rd_add)) rd_val = bc_dt;
  end

  // All outputs are forced to zero while reset is held.
  assign dg_dm_add = (rst && ps_dg_en && !ps_dg_dgsclt) ? addr : 16'h0000;
  assign dg_ps_add = (rst && ps_dg_en &&  ps_dg_dgsclt) ? addr : 16'h0000;
  assign dg_bc_dt  = rst ? rd_val : 16'h0000;

endmodule

// File: tb/tb_dag_unit.sv
// Directed bench for dag_unit: stimulus pushes expected outputs, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_dag_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ps_dg_en = 1'b0;
  logic        ps_dg_dgsclt = 1'b0;
  logic        ps_dg_mdfy = 1'b0;
  logic [2:0]  ps_dg_iadd = '0;
  logic [2:0]  ps_dg_madd = '0;
  logic [4:0]  ps_dg_rd_add = '0;
  logic [4:0]  ps_dg_wrt_add = '0;
  logic        ps_dg_wrt_en = 1'b0;
  logic [15:0] bc_dt = '0;
  logic [15:0] dg_dm_add;
  logic [15:0] dg_ps_add;
  logic [15:0] dg_bc_dt;

  dag_unit dut (
    .clk(clk), .rst(rst),
    .ps_dg_en(ps_dg_en), .ps_dg_dgsclt(ps_dg_dgsclt), .ps_dg_mdfy(ps_dg_mdfy),
    .ps_dg_iadd(ps_dg_iadd), .ps_dg_madd(ps_dg_madd),
    .ps_dg_rd_add(ps_dg_rd_add), .ps_dg_wrt_add(ps_dg_wrt_add), .ps_dg_wrt_en(ps_dg_wrt_en),
    .bc_dt(bc_dt), .dg_dm_add(dg_dm_add), .dg_ps_add(dg_ps_add), .dg_bc_dt(dg_bc_dt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          chk_addr;
    logic [15:0] dm;
    logic [15:0] ps;
    bit          chk_bc;
    logic [15:0] bc;
  } exp_t;

  exp_t sb[$];
  bit   strobe = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents in each strobed cycle.
  always @(negedge clk) begin
    if (strobe) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underflow: got empty queue expected an entry");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk_addr) begin
          check({e.name, ".dm"}, dg_dm_add, e.dm);
          check({e.name, ".ps"}, dg_ps_add, e.ps);
        end
        if (e.chk_bc) check({e.name, ".bc"}, dg_bc_dt, e.bc);
      end
    end
  end

  task automatic idle();
    ps_dg_en = 1'b0; ps_dg_dgsclt = 1'b0; ps_dg_mdfy = 1'b0;
    ps_dg_wrt_en = 1'b0; strobe = 1'b0;
  endtask

  task automatic step(input exp_t e);
    sb.push_back(e);
    strobe = 1'b1;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic step_nochk();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    ps_dg_wrt_add = a; bc_dt = d; ps_dg_wrt_en = 1'b1;
    step_nochk();
  endtask

  task automatic rd(input logic [4:0] a, input logic [15:0] exp, input string name);
    exp_t e;
    ps_dg_rd_add = a;
    e = '{name: name, chk_addr: 1'b0, dm: 16'h0, ps: 16'h0, chk_bc: 1'b1, bc: exp};
    step(e);
  endtask

  task automatic set_gen(input logic [2:0] ia, input logic [2:0] ma, input logic mdfy, input logic sel);
    ps_dg_en = 1'b1; ps_dg_iadd = ia; ps_dg_madd = ma; ps_dg_mdfy = mdfy; ps_dg_dgsclt = sel;
  endtask

  task automatic gen(input logic [2:0] ia, input logic [2:0] ma, input logic mdfy, input logic sel,
                     input logic [15:0] dm, input logic [15:0] ps, input string name);
    exp_t e;
    set_gen(ia, ma, mdfy, sel);
    e = '{name: name, chk_addr: 1'b1, dm: dm, ps: ps, chk_bc: 1'b0, bc: 16'h0};
    step(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    idle();
    repeat (2) @(posedge clk);
    #1;
    // Outputs held at zero during power-on reset, even with a bypassed write.
    set_gen(3'd0, 3'd0, 1'b1, 1'b0);
    ps_dg_wrt_en = 1'b1; ps_dg_wrt_add = 5'b00_000; ps_dg_rd_add = 5'b00_000; bc_dt = 16'h5A5A;
    e = '{name: "por", chk_addr: 1'b1, dm: 16'h0, ps: 16'h0, chk_bc: 1'b1, bc: 16'h0};
    step(e);
    rst = 1'b1;
    rd(5'b00_000, 16'h0000, "por_i0");

    // Back-to-back post-modify on I2 by M3.
    wr(5'b00_010, 16'h0100);
    wr(5'b01_011, 16'h0004);
    gen(3'd2, 3'd3, 1'b0, 1'b0, 16'h0100, 16'h0, "pm0");
    gen(3'd2, 3'd3, 1'b0, 1'b0, 16'h0104, 16'h0, "pm1");
    gen(3'd2, 3'd3, 1'b0, 1'b0, 16'h0108, 16'h0, "pm2");
    rd(5'b00_010, 16'h010C, "pm_i2");

    // Jump target via pre-modify with a negative M.
    wr(5'b00_001, 16'h0040);
    wr(5'b01_001, 16'hFFFE);
    gen(3'd1, 3'd1, 1'b1, 1'b1, 16'h0000, 16'h003E, "jmp");
    rd(5'b00_001, 16'h0040, "jmp_i1");

    // Ureg write wins over post-modify; address uses the pre-edge I4.
    wr(5'b00_100, 16'h0010);
    set_gen(3'd4, 3'd3, 1'b0, 1'b0);
    ps_dg_wrt_en = 1'b1; ps_dg_wrt_add = 5'b00_100; bc_dt = 16'h1234;
    e = '{name: "conf", chk_addr: 1'b1, dm: 16'h0010, ps: 16'h0, chk_bc: 1'b0, bc: 16'h0};
    step(e);
    rd(5'b00_100, 16'h1234, "conf_i4");

    // Same-cycle read bypass.
    ps_dg_wrt_en = 1'b1; ps_dg_wrt_add = 5'b01_010; bc_dt = 16'hBEEF;
    rd(5'b01_010, 16'hBEEF, "byp");
    rd(5'b01_010, 16'hBEEF, "byp_m2");

    // Post-modify wraps mod 2^16.
    wr(5'b00_111, 16'hFFFE);
    wr(5'b01_111, 16'h0004);
    gen(3'd7, 3'd7, 1'b0, 1'b0, 16'hFFFE, 16'h0, "wrap");
    rd(5'b00_111, 16'h0002, "wrap_i7");

`ifdef CIRC_BUF_EN
    wr(5'b11_000, 16'h0200);
    rd(5'b00_000, 16'h0200, "cb_i0_load");
    wr(5'b10_000, 16'h0010);
    wr(5'b01_000, 16'h0006);
    rd(5'b10_000, 16'h0010, "cb_l0");
    rd(5'b11_000, 16'h0200, "cb_b0");
    gen(3'd0, 3'd0, 1'b0, 1'b0, 16'h0200, 16'h0, "cb0");
    gen(3'd0, 3'd0, 1'b0, 1'b0, 16'h0206, 16'h0, "cb1");
    gen(3'd0, 3'd0, 1'b0, 1'b0, 16'h020C, 16'h0, "cb2");
    gen(3'd0, 3'd0, 1'b0, 1'b0, 16'h0202, 16'h0, "cb3");
    gen(3'd0, 3'd0, 1'b0, 1'b0, 16'h0208, 16'h0, "cb4");
    gen(3'd0, 3'd0, 1'b0, 1'b0, 16'h020E, 16'h0, "cb5");
    wr(5'b00_000, 16'h0202);
    wr(5'b01_000, 16'hFFFA);
    gen(3'd0, 3'd0, 1'b0, 1'b0, 16'h0202, 16'h0, "cb_neg");
    rd(5'b00_000, 16'h020C, "cb_neg_i0");
    // Pre-modify past the buffer end is not wrapped.
    wr(5'b01_000, 16'h0006);
    gen(3'd0, 3'd0, 1'b1, 1'b0, 16'h0212, 16'h0, "cb_pre");
    // B write beats a same-cycle post-modify of I0.
    set_gen(3'd0, 3'd0, 1'b0, 1'b0);
    ps_dg_wrt_en = 1'b1; ps_dg_wrt_add = 5'b11_000; bc_dt = 16'h0300;
    e = '{name: "cb_bconf", chk_addr: 1'b1, dm: 16'h020C, ps: 16'h0, chk_bc: 1'b0, bc: 16'h0};
    step(e);
    rd(5'b00_000, 16'h0300, "cb_bconf_i0");
`else
    wr(5'b10_000, 16'h5555);
    rd(5'b10_000, 16'h0000, "nl_l0");
    wr(5'b11_011, 16'h7777);
    rd(5'b11_011, 16'h0000, "nb_b3");
    rd(5'b00_011, 16'h0000, "nb_i3");
`endif

    // Mid-run reset: outputs zero while held, all registers clear afterwards.
    rst = 1'b0;
    set_gen(3'd2, 3'd3, 1'b1, 1'b1);
    ps_dg_wrt_en = 1'b1; ps_dg_wrt_add = 5'b01_001; ps_dg_rd_add = 5'b01_001; bc_dt = 16'hCAFE;
    e = '{name: "rst_hold", chk_addr: 1'b1, dm: 16'h0, ps: 16'h0, chk_bc: 1'b1, bc: 16'h0};
    step(e);
    rst = 1'b1;
    for (int k = 0; k < 32; k++) rd(5'(k), 16'h0000, $sformatf("rst_rd%0d", k));
    gen(3'd2, 3'd3, 1'b1, 1'b0, 16'h0000, 16'h0, "rst_gen");

    @(posedge clk); #1;
    check("sb_drained", 16'(sb.size()), 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
